fir_frame_sequencer: RTL
========================

Name: fir_frame_sequencer

Overview:
Initiator for the FIR sample memory and filter pair. It collects a frame of 8 input samples from a valid/ready stream and parallel-loads them onto c0..c7 with a one-cycle write and FIR reset pulse. It then sweeps addr 0..7, captures out_data at each address, and emits the results as an 18-bit valid/ready stream with a frame-end marker. It replaces hand-driven bench stimulus and sits between the sample source and the memory/FIR blocks.

Parameters:
DW, 8, sample width (equals c0..c7 width)
OW, 18, filter result width (equals out_data width)
LAT, 1, clock cycles from an addr update to a valid out_data (range 1..4)

Ports:
clk  in  1  system clock, all logic on rising edge
rstSeq  in  1  synchronous active-high reset
s_valid  in  1  input sample valid
s_ready  out  1  sequencer accepts a sample
s_data  in  DW  input sample
c0..c7  out  DW each  frame sample registers driven to memory/FIR
write  out  1  memory load strobe
rstFIR  out  1  FIR reset, pulsed together with write
addr  out  3  FIR read address
out_data  in  OW  FIR result for the current addr
m_valid  out  1  result valid
m_ready  in  1  downstream accepts result
m_data  out  OW  captured result
m_last  out  1  high with the result for addr 7
busy  out  1  high in any state except COLLECT

Behaviour:
- Reset, sampled on clk: state=COLLECT, sample index=0, c0..c7=0, write=0, rstFIR=1, addr=0, m_valid=0, m_data=0, m_last=0, s_ready=0, busy=0.
- The cycle after rstSeq falls: rstFIR=0, s_ready=1.
- States: COLLECT, LOAD, WAIT, EMIT.
- COLLECT: s_ready=1. Each s_valid&s_ready cycle writes s_data into c[idx] and increments idx, so the first sample goes to c0.
  - On the 8th accept, go to LOAD. s_ready is registered low the same edge, so the 9th sample is never taken into this frame.
- LOAD, exactly 1 cycle: write=1, rstFIR=1, addr=0, idx cleared. Then go to WAIT with write=0 and rstFIR=0.
- WAIT: hold addr for LAT cycles with a down-counter. On expiry, capture out_data into m_data, set m_valid=1, set m_last=(addr==7), and go to EMIT.
- EMIT: hold m_valid, m_data and m_last stable until m_ready.
  - On the handshake with addr<7: addr+1, m_valid=0, back to WAIT.
  - On the handshake with addr==7: m_valid=0, m_last=0, addr=0, back to COLLECT with s_ready=1 the next cycle.
- addr only changes on an EMIT handshake or on reset. It is never changed while m_valid=1.
- c0..c7 hold their values from LOAD until the next frame's samples overwrite them one by one in COLLECT.
- Per frame: first result m_valid rises LAT+1 cycles after the 8th sample handshake. Without backpressure, results follow every LAT+1 cycles.
- Backpressure: m_ready low stalls the sweep indefinitely with no loss or duplication of results.
- s_valid is ignored outside COLLECT because s_ready=0 there.
- Reset mid-operation, any state: immediate return to reset values.
  - A partial frame is discarded and the index is cleared.
  - An in-flight result is dropped (m_valid=0 the next cycle).
  - rstFIR=1 for the reset cycle(s).
- Reset has priority over every handshake in the same cycle.
- Widths: no arithmetic on data. out_data is captured unmodified at OW bits. The addr and index counters are 3-bit and never wrap mid-frame.

Test Plan:
- Zero frame: 8 samples of 0 with m_ready=1 → write and rstFIR high for exactly 1 cycle, c0..c7=0, addr 0..7 in order, 8 results all 0, m_last only on the 8th.
- Impulse frame {1,0,0,0,0,0,0,0} with a reference FIR model → c0=1 and the rest 0; result k equals the model output at addr k for k=0..7; first m_valid LAT+1 cycles after the 8th accept.
- Backpressure: m_ready held low for 5 cycles when addr=3 → addr stays 3, m_data/m_valid/m_last stable throughout, result 3 delivered exactly once, then addr=4.
- Back-to-back: 16 samples 1..16 with s_valid always high → s_ready low from the 8th accept until the 8th result handshake; after the second LOAD, c0..c7=9..16.
- Reset at addr=5 in EMIT → next cycle m_valid=0, addr=0, busy=0, rstFIR=1; one cycle after reset release s_ready=1; a following 8-sample frame loads normally into c0..c7.
- Partial frame: 5 samples 7,7,7,7,7, then rstSeq for 1 cycle, then 8 samples 1..8 → write pulses once, c0..c7=1..8, no result emitted before that LOAD.

Source files
------------

// File: rtl/fir_frame_sequencer_if.sv
// Stream and memory/FIR signal bundle for the FIR frame sequencer.
// master = the sequencer, slave = the sample source, sink and memory/FIR pair.
interface fir_frame_sequencer_if #(
   parameter int DW = 8,
   parameter int OW = 18
);
   logic          s_valid;
   logic          s_ready;
   logic [DW-1:0] s_data;

   logic [DW-1:0] c0, c1, c2, c3, c4, c5, c6, c7;
   logic          write;
   logic          rstFIR;
   logic [2:0]    addr;
   logic [OW-1:0] out_data;

   logic          m_valid;
   logic          m_ready;
   logic [OW-1:0] m_data;
   logic          m_last;
   logic          busy;

   modport master (
      input  s_valid, s_data, out_data, m_ready,
      output s_ready, c0, c1, c2, c3, c4, c5, c6, c7, write, rstFIR, addr,
             m_valid, m_data, m_last, busy
   );

   modport slave (
      output s_valid, s_data, out_data, m_ready,
      input  s_ready, c0, c1, c2, c3, c4, c5, c6, c7, write, rstFIR, addr,
             m_valid, m_data, m_last, busy
   );
endinterface

// File: rtl/fir_frame_sequencer.sv
// Collects 8 samples, loads them into the memory/FIR pair, then sweeps addr 0..7
// and streams each filter result out with a last marker on addr 7.
module fir_frame_sequencer #(
   parameter int DW  = 8,
   parameter int OW  = 18,
   parameter int LAT = 1
) (
   input  logic                  clk,
   input  logic                  rstSeq,
   fir_frame_sequencer_if.master bus
);

   typedef enum logic [1:0] {COLLECT, LOAD, WAIT, EMIT} state_t;

   state_t        state, state_nxt;
   logic [2:0]    idx;
   logic [2:0]    lat_cnt;
   logic [DW-1:0] c_q [8];
   logic          s_ready_q;
   logic          write_q;
   logic          rst_fir_q;
   logic [2:0]    addr_q;
   logic          m_valid_q;
   logic [OW-1:0] m_data_q;
   logic          m_last_q;
   logic          accept;
   logic          hs;

   assign accept = (state == COLLECT) && bus.s_valid && s_ready_q;
   assign hs     = (state == EMIT) && m_valid_q && bus.m_ready;

   always_ff @(posedge clk) begin
      if (rstSeq) state <= COLLECT;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         COLLECT: if (accept && idx == 3'd7) state_nxt = LOAD;
         LOAD:    state_nxt = WAIT;
         WAIT:    if (lat_cnt == 3'd0) state_nxt = EMIT;
         EMIT:    if (hs) state_nxt = (addr_q == 3'd7) ? COLLECT : WAIT;
         default: state_nxt = COLLECT;
      endcase
   end

   // Handshake flags are registered from the next state so s_ready drops on the 8th accept edge.
   always_ff @(posedge clk) begin
      if (rstSeq) begin
         idx       <= 3'd0;
         lat_cnt   <= 3'd0;
         for (int i = 0; i < 8; i++) c_q[i] <= '0;
         s_ready_q <= 1'b0;
         write_q   <= 1'b0;
         rst_fir_q <= 1'b1;
         addr_q    <= 3'd0;
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
         m_last_q  <= 1'b0;
      end else begin
         s_ready_q <= (state_nxt == COLLECT);
         write_q   <= (state_nxt == LOAD);
         rst_fir_q <= (state_nxt == LOAD);

         if (accept) begin
            c_q[idx] <= bus.s_data;
            idx      <= idx + 3'd1;
         end

         if (state == LOAD) begin
            idx     <= 3'd0;
            addr_q  <= 3'd0;
            lat_cnt <= 3'(LAT - 1);
         end

         if (state == WAIT) begin
            if (lat_cnt == 3'd0) begin
               m_data_q  <= bus.out_data;
               m_valid_q <= 1'b1;
               m_last_q  <= (addr_q == 3'd7);
            end else begin
               lat_cnt <= lat_cnt - 3'd1;
            end
         end

         if (hs) begin
            m_valid_q <= 1'b0;
            lat_cnt   <= 3'(LAT - 1);
            if (addr_q == 3'd7) begin
               m_last_q <= 1'b0;
               addr_q   <= 3'd0;
            end else begin
               addr_q <= addr_q + 3'd1;
            end
         end
      end
   end

   assign bus.s_ready = s_ready_q;
   assign bus.c0      = c_q[0];
   assign bus.c1      = c_q[1];
   assign bus.c2      = c_q[2];
   assign bus.c3      = c_q[3];
   assign bus.c4      = c_q[4];
   assign bus.c5      = c_q[5];
   assign bus.c6      = c_q[6];
   assign bus.c7      = c_q[7];
   assign bus.write   = write_q;
   assign bus.rstFIR  = rst_fir_q;
   assign bus.addr    = addr_q;
   assign bus.m_valid = m_valid_q;
   assign bus.m_data  = m_data_q;
   assign bus.m_last  = m_last_q;
   assign bus.busy    = (state != COLLECT);

endmodule
